fsm_seq_arbiter: RTL and testbench
==================================

// Module: fsm_seq_arbiter
//
// PURPOSE
//   Shares one A/K1/K2 sequence-detector FSM (Idle->Start->Stop->Clear) among
//   N_REQ requesters. Grants one requester at a time, round-robin, and drives A
//   through one full Idle->Start->Stop->Clear->Idle cycle. Confirms the K2
//   (Stop->Clear) and K1 (Clear->Idle) pulses, then signals completion.
//   Sits between the requesting blocks and the detector FSM's A input.
//
// PARAMETERS
//   N_REQ    4   number of requesters, >=2
//   HOLD     2   cycles A is held at each level per phase, >=1
//   TIMEOUT  16  max cycles to wait for K2/K1 in a phase, >HOLD
//
// PORTS
//   Clock  in   1      rising-edge clock
//   Reset  in   1      synchronous, active-low reset
//   req    in   N_REQ  level requests, one bit per requester
//   K1     in   1      K1 from detector FSM (Clear->Idle indication)
//   K2     in   1      K2 from detector FSM (Stop->Clear indication)
//   A      out  1      drives detector FSM input A
//   grant  out  N_REQ  one-hot owner of the detector; 0 when idle
//   done   out  N_REQ  1-cycle pulse on owner bit when sequence completes
//   busy   out  1      1 whenever state != IDLE
//   err    out  1      1-cycle pulse on K1/K2 timeout
//
// BEHAVIOUR
//   - Reset (Reset==0 at posedge): state=IDLE, A=0, grant=0, done=0, busy=0,
//     err=0, RR pointer=N_REQ-1 (req[0] wins first), counters and flags=0.
//     Reset applies mid-sequence too: all outputs return to reset values next edge.
//   - States: IDLE, P0, P1, P2, P3, DONE, ERR. All outputs are registered.
//   - IDLE: A=0. If req!=0, pick the first set bit strictly after the pointer
//     (wrapping). Next cycle: grant=onehot(winner), pointer=winner, state=P0.
//     Latency: req seen at edge n -> grant and A=1 at edge n+1.
//   - P0: A=1 for HOLD cycles (Idle->Start), then P1.
//   - P1: A=0 for HOLD cycles (Start->Stop), then P2.
//   - P2: A=1. Sticky k2_seen is set on any cycle with K2=1 in P2.
//     Leave for P3 when cnt>=HOLD and k2_seen.
//   - P3: A=0. Sticky k1_seen is set on K1=1. Leave for DONE when cnt>=HOLD and
//     k1_seen.
//   - cnt clears on every phase entry. Width is clog2(TIMEOUT+1); it saturates,
//     never wraps.
//   - DONE: 1 cycle. grant=0, done[winner]=1, A=0, then IDLE.
//     Back-to-back requests: next grant comes 1 cycle after DONE.
//   - Grant is held through the whole sequence. A req deassert mid-sequence is
//     ignored: the sequence completes and done still pulses.
//   - Requests arriving mid-sequence wait. Fairness: each active requester is
//     served within N_REQ sequences.
//   - K1/K2 outside P2/P3 are ignored.
//   - ERR: 1 cycle. A=0, grant=0, err=1, done=0, then IDLE. Pointer keeps the
//     failed winner, so the next requester gets priority.
//
// CONFIGURATION
//   FSM_SEQ_TIMEOUT_EN defined:
//     In P2/P3, cnt==TIMEOUT without the required flag -> ERR.
//   FSM_SEQ_TIMEOUT_EN undefined:
//     P2/P3 wait indefinitely, ERR is unreachable, and err is tied to 0.
//
// TESTING
//   1. Reset low 3 cycles, then req=4'b0001; model FSM attached ->
//      grant=0001 next edge; A=1,1,0,0,1,1,0,0 (HOLD=2); done[0] pulse; busy low.
//   2. req=4'b1111 held -> grants 0001,0010,0100,1000,0001; one done pulse per
//      sequence; 1 idle cycle between sequences.
//   3. req[2] asserted 1 cycle only -> full sequence runs, done[2] pulses,
//      no second grant.
//   4. Timeout (EN defined), K2 forced 0 -> in P2, after 16 cycles: err pulse,
//      grant=0, A=0, IDLE. Next req=0101 with pointer=2 -> grant=0001.
//   5. Reset low during P2 -> next edge: A=0, grant=0, busy=0. After release,
//      req=0001 -> clean new sequence.
//   6. Without EN, K1 delayed 40 cycles -> stays in P3 with A=0 and err=0;
//      done follows K1 by 1 cycle (after HOLD met).

Source files
------------

// File: rtl/fsm_seq_arbiter_if.sv
// fsm_seq_arbiter_if
//   Bundles the requester and detector-FSM handshake signals for fsm_seq_arbiter.
//   slave  : arbiter side. It receives req/K1/K2 and drives A/grant/done/busy/err.
//   master : requester/detector side. This is the mirror image of slave.
//   Signals:
//     req   [N_REQ]  level requests, one bit per requester
//     K1, K2         indications from the detector FSM (Clear->Idle, Stop->Clear)
//     A              detector FSM input A
//     grant [N_REQ]  one-hot owner of the detector, 0 when idle
//     done  [N_REQ]  1-cycle completion pulse on the owner bit
//     busy           arbiter is not idle
//     err            1-cycle K1/K2 timeout pulse
interface fsm_seq_arbiter_if #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0] req;
  logic             K1;
  logic             K2;
  logic             A;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] done;
  logic             busy;
  logic             err;

  modport master (output req, K1, K2, input A, grant, done, busy, err);
  modport slave  (input req, K1, K2, output A, grant, done, busy, err);
endinterface

// File: rtl/fsm_seq_arbiter.sv
// fsm_seq_arbiter
//   Shares one A/K1/K2 sequence-detector FSM among N_REQ requesters. Requesters
//   are granted round-robin, one at a time. For each grant the arbiter drives A
//   through one full Idle->Start->Stop->Clear->Idle cycle and confirms the K2
//   and K1 pulses. It then pulses done on the owner bit.
//   Ports:
//     Clock  rising-edge clock
//     Reset  synchronous, active-low reset
//     bus    fsm_seq_arbiter_if.slave (req, K1, K2 in; A, grant, done, busy, err out)
//   Parameters: N_REQ (>=2), HOLD (>=1, cycles per phase), TIMEOUT (>HOLD).
//   Optional feature: define FSM_SEQ_TIMEOUT_EN to abort to ERR when K2 or K1 is
//   missing for TIMEOUT cycles. When it is undefined, the arbiter waits
//   indefinitely and err is tied to 0.
module fsm_seq_arbiter #(
  parameter int N_REQ   = 4,
  parameter int HOLD    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  fsm_seq_arbiter_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_P0, ST_P1, ST_P2, ST_P3, ST_DONE, ST_ERR
  } state_e;

  state_e           state_q, state_d;
  logic             a_q, a_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             k1_seen_q, k1_seen_d;
  logic             k2_seen_q, k2_seen_d;

  logic [CW-1:0]    cnt_inc;
  logic             to_hit;
  logic             found;
  logic [PW-1:0]    win;
  int unsigned      idx;

  // cnt_inc is the number of cycles spent in the current phase, counting this
  // cycle. The phase-exit and timeout decisions compare against cnt_inc so that
  // each phase lasts exactly HOLD (or TIMEOUT) cycles. cnt_inc saturates at
  // TIMEOUT.
  assign cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);

  // Round-robin: take the first set request strictly after ptr_q, wrapping.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = (32'(ptr_q) + i) % N_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    grant_d   = grant_q;
    done_d    = '0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_inc;
    k1_seen_d = k1_seen_q;
    k2_seen_d = k2_seen_q;
    unique case (state_q)
      ST_IDLE: begin
        a_d       = 1'b0;
        grant_d   = '0;
        cnt_d     = '0;
        k1_seen_d = 1'b0;
        k2_seen_d = 1'b0;
        if (found) begin
          state_d = ST_P0;
          a_d     = 1'b1;
          grant_d = N_REQ'(1) << win;
          ptr_d   = win;
        end
      end
      ST_P0: begin
        if (cnt_inc >= CW'(HOLD)) begin
          state_d = ST_P1;
          a_d     = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_P1: begin
        if (cnt_inc >= CW'(HOLD)) begin
          state_d   = ST_P2;
          a_d       = 1'b1;
          cnt_d     = '0;
          k2_seen_d = 1'b0;
        end
      end
      ST_P2: begin
        // A K2 in the current cycle counts immediately, so a pulse on the
        // last hold cycle still lets the phase exit on time.
        k2_seen_d = k2_seen_q | bus.K2;
        if (cnt_inc >= CW'(HOLD) && k2_seen_d) begin
          state_d   = ST_P3;
          a_d       = 1'b0;
          cnt_d     = '0;
          k1_seen_d = 1'b0;
        end else if (to_hit) begin
          state_d = ST_ERR;
          a_d     = 1'b0;
          grant_d = '0;
        end
      end
      ST_P3: begin
        k1_seen_d = k1_seen_q | bus.K1;
        if (cnt_inc >= CW'(HOLD) && k1_seen_d) begin
          state_d = ST_DONE;
          a_d     = 1'b0;
          grant_d = '0;
          done_d  = grant_q;
        end else if (to_hit) begin
          state_d = ST_ERR;
          a_d     = 1'b0;
          grant_d = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      a_q       <= 1'b0;
      grant_q   <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      ptr_q     <= PW'(N_REQ - 1);
      cnt_q     <= '0;
      k1_seen_q <= 1'b0;
      k2_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      k1_seen_q <= k1_seen_d;
      k2_seen_q <= k2_seen_d;
    end
  end

`ifdef FSM_SEQ_TIMEOUT_EN
  logic err_q, err_d;

  assign to_hit = (cnt_inc == CW'(TIMEOUT));

  always_comb err_d = (state_d == ST_ERR);

  always_ff @(posedge Clock) begin
    if (!Reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign to_hit  = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.A     = a_q;
  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_fsm_seq_arbiter.sv
// tb_fsm_seq_arbiter
//   Bench for fsm_seq_arbiter (N_REQ=4, HOLD=2, TIMEOUT=16). It attaches a model
//   of the A/K1/K2 detector FSM, runs a table of round-robin sequences, and then
//   covers the timeout (or the long K1 wait) and a mid-sequence reset.
module tb_fsm_seq_arbiter;
  logic Clock;
  logic Reset;

  fsm_seq_arbiter_if #(.N_REQ(4)) bus ();

  fsm_seq_arbiter #(.N_REQ(4), .HOLD(2), .TIMEOUT(16)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Detector FSM model: Idle -A-> Start -!A-> Stop -A-> Clear(K2) -!A-> Idle(K1)
  typedef enum logic [1:0] {M_IDLE, M_START, M_STOP, M_CLEAR} mstate_e;
  mstate_e m_state;
  logic    m_k1, m_k2;
  logic    k2_block;
  logic    manual_k1;
  logic    k1_man;

  always @(posedge Clock) begin
    if (!Reset) begin
      m_state <= M_IDLE;
      m_k1    <= 1'b0;
      m_k2    <= 1'b0;
    end else begin
      m_k1 <= 1'b0;
      m_k2 <= 1'b0;
      case (m_state)
        M_IDLE:  if (bus.A)  m_state <= M_START;
        M_START: if (!bus.A) m_state <= M_STOP;
        M_STOP:  if (bus.A)  begin m_state <= M_CLEAR; m_k2 <= 1'b1; end
        M_CLEAR: if (!bus.A) begin m_state <= M_IDLE;  m_k1 <= 1'b1; end
        default: m_state <= M_IDLE;
      endcase
    end
  end

  assign bus.K2 = m_k2 & ~k2_block;
  assign bus.K1 = manual_k1 ? k1_man : m_k1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Starts from IDLE and runs one full sequence with the model attached.
  // Cycle 0 is the first cycle that shows grant.
  task automatic run_seq(input logic [3:0] r, input bit one_shot, input logic [3:0] g);
    logic [7:0] a_pat;
    a_pat   = 8'b00110011;
    bus.req = r;
    tick();
    check4("grant", bus.grant, g);
    check1("busy_run", bus.busy, 1'b1);
    if (one_shot) bus.req = '0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      check1("A_phase", bus.A, a_pat[c]);
    end
    check4("grant_held", bus.grant, g);
    check4("done_early", bus.done, 4'b0000);
    tick();
    check4("done_pulse", bus.done, g);
    check4("grant_off", bus.grant, 4'b0000);
    check1("A_done", bus.A, 1'b0);
    check1("err_done", bus.err, 1'b0);
    tick();
    check4("done_clear", bus.done, 4'b0000);
    check1("busy_idle", bus.busy, 1'b0);
  endtask

  typedef struct {
    logic [3:0] req;
    bit         one_shot;
    logic [3:0] exp_grant;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{4'b0001, 1'b0, 4'b0001};
    vecs[1]  = '{4'b1111, 1'b0, 4'b0010};
    vecs[2]  = '{4'b1111, 1'b0, 4'b0100};
    vecs[3]  = '{4'b1111, 1'b0, 4'b1000};
    vecs[4]  = '{4'b1111, 1'b0, 4'b0001};
    vecs[5]  = '{4'b0100, 1'b1, 4'b0100};
    vecs[6]  = '{4'b1010, 1'b0, 4'b1000};
    vecs[7]  = '{4'b0110, 1'b0, 4'b0010};
    vecs[8]  = '{4'b1001, 1'b0, 4'b1000};
    vecs[9]  = '{4'b0011, 1'b0, 4'b0001};
    vecs[10] = '{4'b0100, 1'b1, 4'b0100};

    Reset     = 1'b0;
    bus.req   = '0;
    k2_block  = 1'b0;
    manual_k1 = 1'b0;
    k1_man    = 1'b0;
    tick(); tick(); tick();
    check1("rst_A", bus.A, 1'b0);
    check4("rst_grant", bus.grant, 4'b0000);
    check4("rst_done", bus.done, 4'b0000);
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_err", bus.err, 1'b0);
    Reset = 1'b1;

    for (int v = 0; v < 11; v++) begin
      run_seq(vecs[v].req, vecs[v].one_shot, vecs[v].exp_grant);
    end

    // The one-shot request from the last record must not be granted again.
    for (int c = 0; c < 3; c++) begin
      tick();
      check4("no_regrant", bus.grant, 4'b0000);
    end
    check1("no_regrant_busy", bus.busy, 1'b0);

`ifdef FSM_SEQ_TIMEOUT_EN
    // K2 suppressed: P2 runs 16 cycles, then err pulses. The pointer stays at 2.
    k2_block = 1'b1;
    bus.req  = 4'b0100;
    tick();
    check4("to_grant", bus.grant, 4'b0100);
    bus.req = '0;
    for (int c = 1; c < 20; c++) begin
      tick();
      check1("to_err_quiet", bus.err, 1'b0);
    end
    check1("to_A_p2", bus.A, 1'b1);
    tick();
    check1("to_err", bus.err, 1'b1);
    check4("to_grant_off", bus.grant, 4'b0000);
    check1("to_A", bus.A, 1'b0);
    check4("to_done", bus.done, 4'b0000);
    tick();
    check1("to_err_clear", bus.err, 1'b0);
    check1("to_busy", bus.busy, 1'b0);
    k2_block = 1'b0;
    run_seq(4'b0101, 1'b1, 4'b0001);
`else
    // K1 held off for a long time: the arbiter waits in P3 without an error.
    manual_k1 = 1'b1;
    bus.req   = 4'b0001;
    tick();
    check4("wait_grant", bus.grant, 4'b0001);
    bus.req = '0;
    for (int c = 1; c <= 45; c++) begin
      tick();
      check1("wait_err", bus.err, 1'b0);
    end
    check1("wait_A", bus.A, 1'b0);
    check4("wait_grant_held", bus.grant, 4'b0001);
    check4("wait_done", bus.done, 4'b0000);
    check1("wait_busy", bus.busy, 1'b1);
    k1_man = 1'b1;
    tick();
    k1_man = 1'b0;
    check4("late_done", bus.done, 4'b0001);
    check4("late_grant_off", bus.grant, 4'b0000);
    tick();
    check4("late_done_clear", bus.done, 4'b0000);
    check1("late_busy", bus.busy, 1'b0);
    manual_k1 = 1'b0;
`endif

    // Reset during P2. After the reset the pointer is back at 3, so 0011 grants
    // bit 0. Without the pointer reset, bit 1 would win.
    bus.req = 4'b0001;
    tick();
    check4("mr_grant", bus.grant, 4'b0001);
    bus.req = '0;
    for (int c = 1; c <= 4; c++) tick();
    check1("mr_in_p2", bus.A, 1'b1);
    Reset = 1'b0;
    tick();
    check1("mr_A", bus.A, 1'b0);
    check4("mr_grant_off", bus.grant, 4'b0000);
    check1("mr_busy", bus.busy, 1'b0);
    check4("mr_done", bus.done, 4'b0000);
    Reset = 1'b1;
    run_seq(4'b0011, 1'b1, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
